aes_inv_cipher: RTL and testbench

AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

---
 rtl/aes_inv_cipher.sv | 232 +++++++++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher, iterative, one round per clock on a single round datapath.
// Latency: 20 edges accept->done (10 key-expansion + 10 decrypt); 10 edges on a key-cache hit.
// No backpressure: start is sampled only in IDLE; busy is high otherwise and start is ignored.
//
// Ports: clk, rst (async active-high), start (request pulse), key / cipher_in [0:127]
//        (FIPS-197 byte order, bit 0 = MSB of byte 0), busy, done (1-cycle pulse),
//        plain_out [0:127] (held until the next done).
// Optional build macro: AES_INV_CIPHER_KEY_CACHE_EN keeps round key 10 and the key it
// came from so a repeated key skips the forward key expansion.
module aes_inv_cipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key,
  input  logic [0:127] cipher_in,
  output logic         busy,
  output logic         done,
  output logic [0:127] plain_out
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [127:0] rk, st, cin_lat;
  logic [127:0] rk_fwd, rk_inv, round_out;
  logic         last;
  logic         hit;

  // ---------------- GF(2^8) / S-box helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- key schedule steps ----------------
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: recover the previous round key from the current one.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then optional InvMixColumns.
  // Byte n = row (n%4), column (n/4); row r rotates right by r columns.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [127:0] t, o;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
    t = t ^ k;
    o = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return o;
  endfunction

  // ---------------- datapath combinational ----------------
  // In KEXP rk holds round key cnt-1; in DEC it holds round key 11-cnt.
  assign last      = (cnt == 4'd10);
  assign rk_fwd    = key_fwd(rk, rcon(cnt));
  assign rk_inv    = key_inv(rk, rcon(4'd11 - cnt));
  assign round_out = inv_round(st, rk_inv, !last);
  assign busy      = (state != IDLE);

`ifdef AES_INV_CIPHER_KEY_CACHE_EN
  logic [127:0] cache_key, cache_rk, key_lat;
  logic         cache_vld;
  assign hit = cache_vld && (key == cache_key);
`else
  assign hit = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = hit ? DEC : KEXP;
      KEXP:    if (last) state_nxt = DEC;
      DEC:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      rk        <= '0;
      st        <= '0;
      cin_lat   <= '0;
      plain_out <= '0;
      done      <= 1'b0;
`ifdef AES_INV_CIPHER_KEY_CACHE_EN
      cache_key <= '0;
      cache_rk  <= '0;
      key_lat   <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= 4'd1;
`ifdef AES_INV_CIPHER_KEY_CACHE_EN
            if (hit) begin
              rk <= cache_rk;
              st <= cipher_in ^ cache_rk;
            end else begin
              rk      <= key;
              cin_lat <= cipher_in;
              key_lat <= key;
            end
`else
            rk      <= key;
            cin_lat <= cipher_in;
`endif
          end
        end
        KEXP: begin
          rk <= rk_fwd;
          if (last) begin
            st  <= cin_lat ^ rk_fwd;
            cnt <= 4'd1;
`ifdef AES_INV_CIPHER_KEY_CACHE_EN
            cache_key <= key_lat;
            cache_rk  <= rk_fwd;
            cache_vld <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DEC: begin
          rk <= rk_inv;
          st <= round_out;
          if (last) begin
            plain_out <= round_out;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [0:127] key = '0;
  logic [0:127] cipher_in = '0;
  logic         busy;
  logic         done;
  logic [0:127] plain_out;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;

`ifdef AES_INV_CIPHER_KEY_CACHE_EN
  localparam int LAT_HIT = 10;
`else
  localparam int LAT_HIT = 20;
`endif

  always #5 clk = ~clk;

  aes_inv_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .cipher_in (cipher_in),
    .busy      (busy),
    .done      (done),
    .plain_out (plain_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns the number of edges from the accepting edge to the
  // edge that raised done (-1 on timeout). Returns #1 after that edge, with done high.
  // now=1 drives start immediately instead of waiting for the next falling edge.
  task automatic run_op(input logic [127:0] k, input logic [127:0] c, input bit now,
                        output int lat);
    if (!now) @(negedge clk);
    key = k;
    cipher_in = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone, first, nidle;

    // Reset state
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_plain", plain_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 C.1 vector
    run_op(K1, C1, 1'b0, lat);
    chk("fips_c1_lat", 128'(lat), 128'd20);
    chk("fips_c1_plain", plain_out, P1);
    chk("fips_c1_idle_on_done", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 128'(done), 128'd0);
    chk("plain_held", plain_out, P1);

    // FIPS-197 Appendix B vector
    run_op(K2, C2, 1'b0, lat);
    chk("fips_b_lat", 128'(lat), 128'd20);
    chk("fips_b_plain", plain_out, P2);

    // start held high and inputs scrambled while busy
    @(negedge clk);
    key = K1;
    cipher_in = C1;
    start = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    first = -1;
    nidle = 0;
    for (int n = 1; n <= 20; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) first = n;
      end
      if (n < 20 && !busy) nidle++;
    end
    start = 1'b0;
    chk("held_start_done_count", 128'(ndone), 128'd1);
    chk("held_start_done_edge", 128'(first), 128'd20);
    chk("held_start_busy_gaps", 128'(nidle), 128'd0);
    chk("held_start_plain", plain_out, P1);
    @(posedge clk);
    #1;
    chk("held_start_no_reaccept", 128'(busy), 128'd0);

    // Reset pulsed at edge 12 of an operation
    @(negedge clk);
    key = K2;
    cipher_in = C2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_plain", plain_out, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 128'(ndone), 128'd0);
    chk("abort_plain_stays0", plain_out, 128'd0);
    run_op(K1, C1, 1'b0, lat);
    chk("after_abort_lat", 128'(lat), 128'd20);
    chk("after_abort_plain", plain_out, P1);

    // Back-to-back: second start issued in the done cycle
    run_op(K1, C1, 1'b0, lat);
    chk("b2b_first_lat", 128'(lat), 128'(LAT_HIT));
    chk("b2b_first_plain", plain_out, P1);
    run_op(K2, C2, 1'b1, lat);
    chk("b2b_second_lat", 128'(lat), 128'd20);
    chk("b2b_second_plain", plain_out, P2);

    // Repeated key (cache hit when enabled), key change, repeat, then reset
    run_op(K2, C3, 1'b0, lat);
    chk("repeat_key_lat", 128'(lat), 128'(LAT_HIT));
    chk("repeat_key_plain", plain_out, P3);
    run_op(K1, C1, 1'b0, lat);
    chk("new_key_lat", 128'(lat), 128'd20);
    chk("new_key_plain", plain_out, P1);
    run_op(K1, C1, 1'b0, lat);
    chk("refreshed_key_lat", 128'(lat), 128'(LAT_HIT));
    chk("refreshed_key_plain", plain_out, P1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(K1, C1, 1'b0, lat);
    chk("post_reset_lat", 128'(lat), 128'd20);
    chk("post_reset_plain", plain_out, P1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
